// File: rtl/pending_encoder_32_to_5.sv
// pending_encoder_32_to_5
//
// Sequential 32-to-5 encoder. A non-zero 32-bit request vector is captured on
// an accepted load. The 5-bit index of every set bit is then presented on
// `out`, lowest index first, one index per out_valid/out_ready handshake.
// After the last index of a vector is accepted, `done` pulses for one cycle
// and the block returns to idle.
//
// Ports
//   clock       in   1   rising-edge clock
//   reset       in   1   asynchronous, active-high reset of all state
//   load        in   1   capture `in` (honoured only while load_ready=1)
//   in          in   32  request vector; bit i set means index i pending
//   load_ready  out  1   idle and able to accept a load
//   out         out  5   index of the lowest still-pending bit
//   out_valid   out  1   `out` holds a valid index
//   out_ready   in   1   consumer accepts `out` this cycle
//   remaining   out  6   pending bits not yet accepted (0..32)
//   done        out  1   one-cycle pulse after the final index is accepted
//
// Every output comes from a register (load_ready decodes the state register
// only), so there is no combinational path from `in` or `out_ready`.

module pending_encoder_32_to_5 (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] in,
    output logic        load_ready,
    output logic [4:0]  out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  remaining,
    output logic        done
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pending;
    logic [31:0] pending_nxt;
    logic [31:0] pending_clr;
    logic [4:0]  out_nxt;
    logic        out_valid_nxt;
    logic [5:0]  remaining_nxt;
    logic        done_nxt;

    // Index of the lowest set bit; bit 0 has the highest priority.
    // The caller guarantees v is non-zero.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

    // Number of set bits; 6 bits wide so that 32 is representable.
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, v[i]};
        end
        return cnt;
    endfunction

    assign load_ready = (state == IDLE);

    // Next-state / next-output logic
    always_comb begin
        state_nxt     = state;
        pending_nxt   = pending;
        out_nxt       = out;
        out_valid_nxt = out_valid;
        remaining_nxt = remaining;
        done_nxt      = 1'b0;
        // Pending vector with the index currently on `out` retired.
        pending_clr   = pending & ~(32'd1 << out);

        case (state)
            IDLE: begin
                // An all-zero vector has nothing to emit and is dropped.
                if (load && (in != 32'd0)) begin
                    pending_nxt   = in;
                    out_nxt       = lowest_set(in);
                    remaining_nxt = popcount(in);
                    out_valid_nxt = 1'b1;
                    state_nxt     = EMIT;
                end
            end

            EMIT: begin
                // Without a handshake everything holds, keeping `out`
                // stable under backpressure.
                if (out_valid && out_ready) begin
                    pending_nxt   = pending_clr;
                    remaining_nxt = remaining - 6'd1;
                    if (pending_clr != 32'd0) begin
                        out_nxt = lowest_set(pending_clr);
                    end else begin
                        out_valid_nxt = 1'b0;
                        out_nxt       = 5'd0;
                        done_nxt      = 1'b1;
                        state_nxt     = IDLE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= 32'd0;
            out       <= 5'd0;
            out_valid <= 1'b0;
            remaining <= 6'd0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            out       <= out_nxt;
            out_valid <= out_valid_nxt;
            remaining <= remaining_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pending_encoder_32_to_5.sv
// tb_pending_encoder_32_to_5
//
// Scoreboard bench for pending_encoder_32_to_5. The stimulus side pushes, for
// every accepted vector, the ascending list of its set-bit indices together
// with the count still outstanding at each step. A negedge monitor compares
// the DUT outputs against the head of that list every cycle and pops on a
// handshake. Directed scenarios are followed by randomized vectors with
// random backpressure.

module tb_pending_encoder_32_to_5;

    logic        clock;
    logic        reset;
    logic        load;
    logic [31:0] in;
    logic        load_ready;
    logic [4:0]  out;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  remaining;
    logic        done;

    typedef struct {
        logic [4:0] idx;
        logic [5:0] rem;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    bit   done_due;
    int   checks;
    int   errors;

    pending_encoder_32_to_5 dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .in         (in),
        .load_ready (load_ready),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .remaining  (remaining),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a vector expands to its set-bit indices in ascending
    // order; the outstanding count at each step is what is still left.
    task automatic push_vector(input logic [31:0] v);
        int left;
        exp_t x;
        left = $countones(v);
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                x.idx = 5'(i);
                x.rem = 6'(left);
                sb.push_back(x);
                left--;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a load for one cycle. The model is idle exactly when nothing is
    // outstanding in the scoreboard.
    task automatic do_load(input logic [31:0] v);
        bit accept;
        load   = 1'b1;
        in     = v;
        accept = (sb.size() == 0);
        @(posedge clock);
        if (accept && (v != 32'd0)) push_vector(v);
        #1;
        load = 1'b0;
        in   = $urandom;
    endtask

    task automatic drain(input int budget, input int expect_cycles, input bit rand_ready);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d entries left expected 0 after %0d cycles", sb.size(), n);
            sb.delete();
        end else if (expect_cycles >= 0) begin
            chk("drain_cycles", n, expect_cycles);
        end
    endtask

    // Monitor: every cycle, away from the active edge.
    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
            done_due = 1'b0;
            chk("done_in_reset", done, 0);
        end else begin
            chk("load_ready", load_ready, (sb.size() == 0));
            chk("done", done, done_due);
            done_due = 1'b0;
            if (sb.size() == 0) begin
                chk("out_valid_idle", out_valid, 0);
                chk("out_idle", out, 0);
                chk("remaining_idle", remaining, 0);
            end else begin
                e = sb[0];
                chk("out_valid", out_valid, 1);
                chk("out", out, e.idx);
                chk("remaining", remaining, e.rem);
                if (out_ready) begin
                    void'(sb.pop_front());
                    done_due = (e.rem == 6'd1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        checks    = 0;
        errors    = 0;
        done_due  = 1'b0;
        reset     = 1'b1;
        load      = 1'b0;
        in        = 32'd0;
        out_ready = 1'b0;

        // Reset values
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_done", done, 0);
        chk("rst_load_ready", load_ready, 1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single bit
        out_ready = 1'b1;
        do_load(32'h0000_0001);
        drain(10, 1, 1'b0);
        tick();

        // Extremes
        do_load(32'h8000_0001);
        drain(10, 2, 1'b0);
        tick();

        // Full vector
        do_load(32'hFFFF_FFFF);
        drain(40, 32, 1'b0);
        tick();

        // Backpressure with an ignored load while busy
        out_ready = 1'b0;
        do_load(32'h0000_0110);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out", out, 4);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_remaining", remaining, 2);
            if (i == 2) do_load(32'hFFFF_FFFF);
            else        tick();
        end
        out_ready = 1'b1;
        drain(10, 2, 1'b0);
        tick();

        // Reset in the middle of a vector
        out_ready = 1'b0;
        do_load(32'h0000_F000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pre_rst_out", out, 13);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out", out, 0);
        chk("mid_rst_remaining", remaining, 0);
        chk("mid_rst_load_ready", load_ready, 1);
        chk("mid_rst_done", done, 0);
        #4;
        reset = 1'b0;
        tick();
        out_ready = 1'b1;
        do_load(32'h0000_0004);
        drain(10, 1, 1'b0);
        tick();

        // Zero load, then back-to-back vectors through the done cycle
        do_load(32'h0000_0000);
        tick();
        tick();
        do_load(32'h0000_0002);
        drain(10, 1, 1'b0);
        chk("b2b_done", done, 1);
        chk("b2b_load_ready", load_ready, 1);
        do_load(32'h0000_0008);
        drain(10, 1, 1'b0);
        tick();

        // Randomized vectors with random backpressure and busy loads
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom;
                1:       v = $urandom & $urandom & $urandom;
                2:       v = 32'd1 << $urandom_range(0, 31);
                default: v = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom | 32'h8000_0000);
            endcase
            out_ready = 1'($urandom_range(0, 1));
            do_load(v);
            if ($urandom_range(0, 3) == 0) do_load($urandom);
            drain(400, -1, 1'b1);
            if ($urandom_range(0, 1) == 0) tick();
        end
        out_ready = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
